// File: rtl/udp_panel_reader.sv
// Panel readback transmitter: reads a run of framebuffer pixels over the ctrl read
// port and streams them as one UDP packet, packed as the inverse of the write path.
`timescale 1ns/1ps

module udp_panel_reader #(
    parameter logic [7:0] PORT_MSB     = 8'h80,
    parameter int         READ_LATENCY = 1,
    parameter int         MAX_WORDS    = 256
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_panel,
    input  logic [13:0] req_addr,
    input  logic [15:0] req_count,
    input  logic [31:0] req_ip,
    input  logic [15:0] req_port,

    output logic [5:0]  ctrl_ren,
    output logic [15:0] ctrl_addr,
    input  logic [23:0] ctrl_rdat,

    output logic        udp_sink_valid,
    output logic        udp_sink_last,
    input  logic        udp_sink_ready,
    output logic [15:0] udp_sink_src_port,
    output logic [15:0] udp_sink_dst_port,
    output logic [31:0] udp_sink_ip_address,
    output logic [15:0] udp_sink_length,
    output logic [31:0] udp_sink_data,

    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND
    } state_t;

    localparam logic [2:0]  WAIT_LAST = 3'(READ_LATENCY - 1);
    localparam logic [15:0] MAX_CNT   = 16'(MAX_WORDS);

    function automatic logic [2:0] lowest_idx(input logic [5:0] p);
        logic [2:0] idx;
        idx = 3'd0;
        // Scan downwards so the lowest set bit is the one that sticks.
        for (int i = 5; i >= 0; i--) begin
            if (p[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    state_t      state_q;
    logic [5:0]  panel_oh_q;
    logic [13:0] cur_addr_q;
    logic [15:0] remaining_q;
    logic [2:0]  wait_cnt_q;

    logic [5:0]  ctrl_ren_q;
    logic [15:0] ctrl_addr_q;
    logic        valid_q;
    logic        last_q;
    logic [15:0] src_port_q;
    logic [15:0] dst_port_q;
    logic [31:0] ip_q;
    logic [15:0] length_q;
    logic [31:0] data_q;

    logic [15:0] count_d;
    logic [5:0]  panel_oh_d;
    logic [2:0]  panel_idx_d;
    logic [13:0] next_addr_d;
    logic [31:0] pack_d;
    logic        unused_rdat;

    assign count_d     = (req_count > MAX_CNT) ? MAX_CNT : req_count;
    assign panel_oh_d  = req_panel & (~req_panel + 6'd1);
    assign panel_idx_d = lowest_idx(req_panel);
    assign next_addr_d = cur_addr_q + 14'd1;

    // Address and channel bits interleaved so the word is a valid write payload.
    assign pack_d = {ctrl_rdat[9:8], ctrl_rdat[5:0], ctrl_rdat[19:16], ctrl_rdat[13:10],
                     cur_addr_q[5:0], ctrl_rdat[21:20], cur_addr_q[13:6]};

    assign unused_rdat = ^{ctrl_rdat[23:22], ctrl_rdat[15:14], ctrl_rdat[7:6]};

    always_ff @(posedge clk) begin
        // NOTE: the synchronous reset clears every output register so the sink never sees a stale beat.
        if (reset) begin
            state_q     <= S_IDLE;
            panel_oh_q  <= '0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            wait_cnt_q  <= '0;
            ctrl_ren_q  <= '0;
            ctrl_addr_q <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            src_port_q  <= '0;
            dst_port_q  <= '0;
            ip_q        <= '0;
            length_q    <= '0;
            data_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        panel_oh_q  <= panel_oh_d;
                        cur_addr_q  <= req_addr;
                        remaining_q <= count_d;
                        src_port_q  <= {PORT_MSB, 2'b00, 3'b000, panel_idx_d};
                        dst_port_q  <= req_port;
                        ip_q        <= req_ip;
                        length_q    <= {count_d[13:0], 2'b00};
                        if (count_d != 16'd0) begin
                            state_q     <= S_READ;
                            ctrl_ren_q  <= panel_oh_d;
                            ctrl_addr_q <= {2'b00, req_addr};
                        end
                    end
                end
                S_READ: begin
                    ctrl_ren_q <= '0;
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        data_q  <= pack_d;
                        valid_q <= 1'b1;
                        last_q  <= (remaining_q == 16'd1);
                        state_q <= S_SEND;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 3'd1;
                    end
                end
                S_SEND: begin
                    if (udp_sink_ready) begin
                        valid_q     <= 1'b0;
                        last_q      <= 1'b0;
                        cur_addr_q  <= next_addr_d;
                        remaining_q <= remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q     <= S_READ;
                            ctrl_ren_q  <= panel_oh_q;
                            ctrl_addr_q <= {2'b00, next_addr_d};
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready           = (state_q == S_IDLE);
    assign busy                = (state_q != S_IDLE);
    assign ctrl_ren            = ctrl_ren_q;
    assign ctrl_addr           = ctrl_addr_q;
    assign udp_sink_valid      = valid_q;
    assign udp_sink_last       = last_q;
    assign udp_sink_src_port   = src_port_q;
    assign udp_sink_dst_port   = dst_port_q;
    assign udp_sink_ip_address = ip_q;
    assign udp_sink_length     = length_q;
    assign udp_sink_data       = data_q;

endmodule

// File: tb/tb_udp_panel_reader.sv
// Directed bench for udp_panel_reader with a one-cycle-latency framebuffer model.
`timescale 1ns/1ps

module tb_udp_panel_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_panel;
    logic [13:0] req_addr;
    logic [15:0] req_count;
    logic [31:0] req_ip;
    logic [15:0] req_port;
    logic [5:0]  ctrl_ren;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_rdat = 24'h0;
    logic        udp_sink_valid;
    logic        udp_sink_last;
    logic        udp_sink_ready;
    logic [15:0] udp_sink_src_port;
    logic [15:0] udp_sink_dst_port;
    logic [31:0] udp_sink_ip_address;
    logic [15:0] udp_sink_length;
    logic [31:0] udp_sink_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [15:0] len;
        logic [15:0] src;
        logic [15:0] dst;
        logic [31:0] ip;
    } beat_t;

    beat_t       beats[$];
    logic [15:0] ren_addr[$];
    logic [5:0]  ren_val[$];
    int          ren_cyc[$];

    udp_panel_reader dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_panel           (req_panel),
        .req_addr            (req_addr),
        .req_count           (req_count),
        .req_ip              (req_ip),
        .req_port            (req_port),
        .ctrl_ren            (ctrl_ren),
        .ctrl_addr           (ctrl_addr),
        .ctrl_rdat           (ctrl_rdat),
        .udp_sink_valid      (udp_sink_valid),
        .udp_sink_last       (udp_sink_last),
        .udp_sink_ready      (udp_sink_ready),
        .udp_sink_src_port   (udp_sink_src_port),
        .udp_sink_dst_port   (udp_sink_dst_port),
        .udp_sink_ip_address (udp_sink_ip_address),
        .udp_sink_length     (udp_sink_length),
        .udp_sink_data       (udp_sink_data),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    // Framebuffer: valid data only in the cycle after a read strobe.
    always @(posedge clk) begin
        ctrl_rdat <= (ctrl_ren != 6'd0) ? 24'h2A153F : 24'h000000;
    end

    always @(negedge clk) begin
        cycle++;
        if (ctrl_ren != 6'd0) begin
            ren_addr.push_back(ctrl_addr);
            ren_val.push_back(ctrl_ren);
            ren_cyc.push_back(cycle);
        end
        if (udp_sink_valid && udp_sink_ready) begin
            beats.push_back('{udp_sink_data, udp_sink_last, udp_sink_length,
                              udp_sink_src_port, udp_sink_dst_port, udp_sink_ip_address});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic clear_logs();
        beats.delete();
        ren_addr.delete();
        ren_val.delete();
        ren_cyc.delete();
    endtask

    task automatic send_req(input logic [5:0] panel, input logic [13:0] addr, input logic [15:0] count,
                            input logic [31:0] ip, input logic [15:0] port);
        @(posedge clk); #1;
        req_panel = panel;
        req_addr  = addr;
        req_count = count;
        req_ip    = ip;
        req_port  = port;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lasts;
        int last_pos;
        logic seen;

        reset          = 1'b1;
        req_valid      = 1'b0;
        req_panel      = '0;
        req_addr       = '0;
        req_count      = '0;
        req_ip         = '0;
        req_port       = '0;
        udp_sink_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_valid_last_ren", {24'd0, udp_sink_valid, udp_sink_last, ctrl_ren}, 32'd0);
        check("rst_ctrl_addr", {16'd0, ctrl_addr}, 32'd0);
        check("rst_data",      udp_sink_data, 32'd0);
        check("rst_ip",        udp_sink_ip_address, 32'd0);
        check("rst_ports",     {udp_sink_src_port, udp_sink_dst_port}, 32'd0);
        check("rst_length",    {16'd0, udp_sink_length}, 32'd0);
        reset = 1'b0;

        // Two words from panel 2, sink always ready
        clear_logs();
        send_req(6'b000100, 14'h0010, 16'd2, 32'hC0A80001, 16'h1234);
        wait_idle("t1_done", 100);
        check("t1_ren_count", ren_val.size(), 2);
        check("t1_beat_count", beats.size(), 2);
        if (ren_val.size() == 2) begin
            check("t1_ren0", {26'd0, ren_val[0]}, 32'h04);
            check("t1_ren1", {26'd0, ren_val[1]}, 32'h04);
            check("t1_addr0", {16'd0, ren_addr[0]}, 32'h0010);
            check("t1_addr1", {16'd0, ren_addr[1]}, 32'h0011);
            check("t1_spacing", ren_cyc[1] - ren_cyc[0], 3);
        end
        if (beats.size() == 2) begin
            check("t1_data0", beats[0].data, 32'h7FA54200);
            check("t1_data1", beats[1].data, 32'h7FA54600);
            check("t1_last0", {31'd0, beats[0].last}, 32'd0);
            check("t1_last1", {31'd0, beats[1].last}, 32'd1);
            check("t1_len",   {16'd0, beats[1].len}, 32'd8);
            check("t1_src",   {16'd0, beats[0].src}, 32'h8002);
            check("t1_dst",   {16'd0, beats[1].dst}, 32'h1234);
            check("t1_ip",    beats[0].ip, 32'hC0A80001);
        end

        // One word from panel 5 with backpressure
        clear_logs();
        udp_sink_ready = 1'b0;
        send_req(6'b100000, 14'h0123, 16'd1, 32'h0A000002, 16'h4321);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (udp_sink_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("t2_valid_seen", {31'd0, seen}, 32'd1);
        for (int n = 0; n < 5; n++) begin
            check("t2_hold_valid", {31'd0, udp_sink_valid}, 32'd1);
            check("t2_hold_last",  {31'd0, udp_sink_last}, 32'd1);
            check("t2_hold_data",  udp_sink_data, 32'h7FA58E04);
            @(posedge clk); #1;
        end
        udp_sink_ready = 1'b1;
        check("t2_busy_during", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("t2_busy_after",  {31'd0, busy}, 32'd0);
        check("t2_valid_after", {31'd0, udp_sink_valid}, 32'd0);
        check("t2_beat_count", beats.size(), 1);
        check("t2_ren_count", ren_val.size(), 1);
        if (beats.size() == 1) begin
            check("t2_src", {16'd0, beats[0].src}, 32'h8005);
            check("t2_len", {16'd0, beats[0].len}, 32'd4);
        end

        // Address wrap at the top of the 14-bit range
        clear_logs();
        send_req(6'b000010, 14'h3FFF, 16'd2, 32'h0A000003, 16'h0100);
        wait_idle("t3_done", 100);
        check("t3_ren_count", ren_val.size(), 2);
        if (ren_addr.size() == 2) begin
            check("t3_addr0", {16'd0, ren_addr[0]}, 32'h3FFF);
            check("t3_addr1", {16'd0, ren_addr[1]}, 32'h0000);
        end
        check("t3_beat_count", beats.size(), 2);
        if (beats.size() == 2) begin
            check("t3_data0", beats[0].data, 32'h7FA5FEFF);
            check("t3_data1", beats[1].data, 32'h7FA50200);
            check("t3_src",   {16'd0, beats[0].src}, 32'h8001);
        end

        // Oversized request is clamped to MAX_WORDS
        clear_logs();
        send_req(6'b000001, 14'h0000, 16'd1000, 32'h0A000004, 16'h0200);
        wait_idle("t4_done", 2000);
        check("t4_beat_count", beats.size(), 256);
        check("t4_ren_count", ren_val.size(), 256);
        lasts = 0;
        last_pos = -1;
        foreach (beats[i]) begin
            if (beats[i].last) begin
                lasts++;
                last_pos = i;
            end
        end
        check("t4_last_count", lasts, 1);
        check("t4_last_pos", last_pos, 255);
        if (beats.size() > 0) check("t4_len", {16'd0, beats[0].len}, 32'd1024);

        // Zero-length request is consumed without a packet
        clear_logs();
        send_req(6'b001000, 14'h0055, 16'd0, 32'h0A000005, 16'h0300);
        check("t5_ready_now", {31'd0, req_ready}, 32'd1);
        check("t5_busy_now",  {31'd0, busy}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("t5_ren_count", ren_val.size(), 0);
        check("t5_beat_count", beats.size(), 0);
        check("t5_ready_later", {31'd0, req_ready}, 32'd1);

        // Reset during the third of four beats
        clear_logs();
        send_req(6'b010000, 14'h0100, 16'd4, 32'h0A000006, 16'h0400);
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (udp_sink_valid && beats.size() == 2) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("t6_beat3_seen", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_valid", {31'd0, udp_sink_valid}, 32'd0);
        check("t6_last",  {31'd0, udp_sink_last}, 32'd0);
        check("t6_ren",   {26'd0, ctrl_ren}, 32'd0);
        check("t6_ready", {31'd0, req_ready}, 32'd1);
        check("t6_busy",  {31'd0, busy}, 32'd0);
        reset = 1'b0;
        lasts = 0;
        foreach (beats[i]) if (beats[i].last) lasts++;
        check("t6_no_last", lasts, 0);

        clear_logs();
        send_req(6'b010000, 14'h0200, 16'd1, 32'h0A000007, 16'h0500);
        wait_idle("t6b_done", 100);
        check("t6b_beat_count", beats.size(), 1);
        if (beats.size() == 1) begin
            check("t6b_data", beats[0].data, 32'h7FA50208);
            check("t6b_last", {31'd0, beats[0].last}, 32'd1);
            check("t6b_src",  {16'd0, beats[0].src}, 32'h8004);
            check("t6b_ip",   beats[0].ip, 32'h0A000007);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_panel_reader.md
Name: udp_panel_reader

Overview:
- Readback transmitter for the LED panel control bus: accepts a read request, reads a run of panel pixels over the ctrl read port, and streams them as one UDP packet into the UDP core sink.
- Payload word format is the exact inverse of the panel write path, so the host can send a readback payload straight back as a write payload.
- Sits beside the UDP panel write path, between the UDP core and the panel framebuffer read port.

Parameters:
- PORT_MSB, 8'h80, upper byte of the UDP source port stamped on outgoing packets.
- READ_LATENCY, 1, cycles from ctrl_ren/ctrl_addr sampled to ctrl_rdat valid (1..7).
- MAX_WORDS, 256, maximum payload words per packet; larger requests are clamped.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  read request strobe.
- req_ready  out  1  high when idle; request accepted on req_valid & req_ready.
- req_panel  in  6  one-hot panel select.
- req_addr  in  14  first pixel address.
- req_count  in  16  pixel words to read.
- req_ip  in  32  destination IP.
- req_port  in  16  destination UDP port.
- ctrl_ren  out  6  read enable, one-hot, one cycle per word.
- ctrl_addr  out  16  read address; [15:14] always 0.
- ctrl_rdat  in  24  read data: 6-bit channels in [21:16], [13:8], [5:0].
- udp_sink_valid  out  1  payload word valid.
- udp_sink_last  out  1  final word of packet.
- udp_sink_ready  in  1  sink accepts word.
- udp_sink_src_port  out  16  {PORT_MSB, 2'b00, latched panel index 0..5}.
- udp_sink_dst_port  out  16  latched req_port.
- udp_sink_ip_address  out  32  latched req_ip.
- udp_sink_length  out  16  payload bytes = 4 * clamped count.
- udp_sink_data  out  32  packed word.
- busy  out  1  high in any state but IDLE.

Behaviour:
- Reset: all outputs 0 except req_ready = 1. Reset mid-packet returns to IDLE at once; valid drops with no last beat.
- States:
  - IDLE: req_ready = 1. On accept, latch panel/ip/port/addr and set count = min(req_count, MAX_WORDS).
    - count = 0: request consumed, no packet, stay IDLE.
    - Otherwise go to READ.
  - READ: one cycle; ctrl_ren = latched panel, ctrl_addr = {2'b00, cur_addr}. Go to WAIT.
  - WAIT: count READ_LATENCY cycles, then capture ctrl_rdat into the data register. Go to SEND.
  - SEND: udp_sink_valid = 1; data and all header fields held stable until udp_sink_ready.
    - On the handshake, increment cur_addr mod 2^14 (0x3FFF wraps to 0x0000) and decrement remaining.
    - remaining was 1: go to IDLE, busy clears the next cycle.
    - Otherwise go to READ.
- ctrl_ren is 0 outside READ; ctrl_addr holds its last value.
- Panel index is the position of the lowest set bit in req_panel; req_panel = 0 gives index 0 and ctrl_ren stays 0.
- udp_sink_last = 1 on the final word only, held with valid.
- Header outputs are constant for the whole packet.
- Packing (A = address, D = rdat):
  - data[7:0] = A[13:6], data[15:10] = A[5:0].
  - data[9:8] = D[21:20], data[23:20] = D[19:16].
  - data[19:16] = D[13:10], data[31:30] = D[9:8].
  - data[29:24] = D[5:0].
  - Bits D[23:22], D[15:14] and D[7:6] are dropped.
- Throughput: one word per READ_LATENCY+2 cycles with the sink always ready.
- req_valid while busy: not accepted, since req_ready = 0.

Test Plan:
- Panel 6'b000100, addr 0x0010, count 2, rdat 0x2A153F, sink always ready -> two ctrl_ren=6'b000100 pulses at 0x0010 and 0x0011; length 8; src_port 0x8002; each data word = pack(addr, 0x2A153F); last only on beat 2.
- Count 1 with udp_sink_ready low for 5 cycles -> valid/data/last held constant for 5 cycles; exactly one transfer; busy falls one cycle after it.
- Addr 0x3FFF, count 2 -> second read at ctrl_addr 0x0000.
- req_count 1000 -> length 1024; exactly 256 beats; last on beat 256.
- req_count 0 -> accepted; no ctrl_ren and no valid; req_ready stays 1.
- Reset asserted at beat 3 of 4 -> next cycle valid = 0, ctrl_ren = 0, req_ready = 1; a new request then runs normally.
